// File: rtl/sumator_pkg.sv
// Shared types and constants for the sumator_seq sequential adder.
// Holds the FSM state encoding, the slice width and the index-width helper.
package sumator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 2;

    // Bits needed for the slice index: clog2(width/2), at least 1.
    function automatic int idx_w(input int width);
        int n;
        int r;
        n = width / SLICE_W;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sumator_slice.sv
// Combinational 2-bit adder slice with carry-in, reused every cycle by sumator_seq.
// Ports: a, b (2-bit addends), cin (carry in), s (2-bit sum), cout (carry out).
module sumator_slice
    import sumator_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/sumator_seq.sv
// Sequential WIDTH-bit adder: one shared 2-bit slice, low slice first, WIDTH/2 cycles.
// Ports: clk, rst_n, start/ready handshake, a/b operands, busy, done pulse, y (WIDTH+1 sum).
module sumator_seq
    import sumator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   y
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int KW  = idx_w(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH:0]   y_q, y_d;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_cout;

    // Route the operand bits of the current slice to the shared adder.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NSL; i++) begin
            if (k_q == KW'(i)) begin
                sl_a = opa_q[i*SLICE_W +: SLICE_W];
                sl_b = opb_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    sumator_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        k_d     = k_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = 1'b0;
                    k_d     = '0;
                    y_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Per-slice write enable: only the current slice of y changes.
                for (int i = 0; i < NSL; i++) begin
                    if (k_q == KW'(i)) begin
                        y_d[i*SLICE_W +: SLICE_W] = sl_s;
                    end
                end
                carry_d = sl_cout;
                if (k_q == K_LAST) begin
                    y_d[WIDTH] = sl_cout;
                    state_d    = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            y_q     <= y_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign y     = y_q;

endmodule

// File: tb/tb_sumator_seq.sv
// Self-checking bench for sumator_seq (WIDTH=8 directed/random, WIDTH=4 exhaustive).
// Expected sums come from plain arithmetic on the applied operands.
module tb_sumator_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [8:0] y;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ready4;
    logic       busy4;
    logic       done4;
    logic [4:0] y4;

    int n_cmp;
    int n_bad;

    sumator_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    sumator_seq #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .ready (ready4),
        .busy  (busy4),
        .done  (done4),
        .y     (y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready8();
        int t;
        t = 0;
        while (!ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready8_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic wait_ready4();
        int t;
        t = 0;
        while (!ready4 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ready4) chk("ready4_timeout", {31'd0, ready4}, 32'd1);
    endtask

    // One WIDTH=8 transaction with per-edge checks; optionally re-pulses
    // start with other operands during RUN.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [8:0] exp, input bit repulse);
        logic [8:0] part;
        int         m;
        wait_ready8();
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("e0_ready", {31'd0, ready}, 32'd0);
        chk("e0_busy", {31'd0, busy}, 32'd1);
        chk("e0_y", {23'd0, y}, 32'd0);
        for (int j = 1; j <= 4; j++) begin
            if (repulse && j == 2) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h11;
            end
            if (repulse && j == 3) start = 1'b0;
            @(negedge clk);
            if (j < 4) begin
                m    = (1 << (2 * j)) - 1;
                part = 9'(((int'(av) & m) + (int'(bv) & m)) & m);
            end else begin
                part = exp;
            end
            chk($sformatf("slice%0d_y", j), {23'd0, y}, {23'd0, part});
            chk($sformatf("slice%0d_done", j), {31'd0, done},
                {31'd0, (j == 4)});
            chk($sformatf("slice%0d_ready", j), {31'd0, ready}, 32'd0);
        end
        @(negedge clk);
        chk("e5_done", {31'd0, done}, 32'd0);
        chk("e5_ready", {31'd0, ready}, 32'd1);
        chk("e5_hold_y", {23'd0, y}, {23'd0, exp});
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv);
        int         cnt;
        logic [4:0] got;
        wait_ready4();
        a4     = av;
        b4     = bv;
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        cnt = 0;
        got = '0;
        repeat (5) begin
            @(negedge clk);
            if (done4) begin
                cnt++;
                got = y4;
            end
        end
        chk("w4_done_count", cnt, 32'd1);
        chk("w4_sum", {27'd0, got}, {27'd0, 5'(av) + 5'(bv)});
    endtask

    vec_t vecs[4];

    initial begin
        int         dcnt;
        logic [7:0] ra;
        logic [7:0] rb;
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;

        vecs[0] = '{8'h00, 8'h00, 9'h000};
        vecs[1] = '{8'hFF, 8'h01, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[3] = '{8'hA5, 8'h5A, 9'h0FF};

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_y", {23'd0, y}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        // start re-pulsed during RUN must be ignored
        run8(8'h3C, 8'h27, 9'h063, 1'b1);

        // reset after E2: immediate idle, no done
        wait_ready8();
        a     = 8'h77;
        b     = 8'h66;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_y", {23'd0, y}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 32'd0);
        run8(8'h03, 8'h01, 9'h004, 1'b0);

        // start held high: one acceptance per return to IDLE
        wait_ready8();
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        dcnt  = 0;
        repeat (24) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("b2b_y", {23'd0, y}, 32'h046);
            end
        end
        start = 1'b0;
        chk("b2b_done_count", dcnt, 32'd4);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 9'(ra) + 9'(rb), 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
